// File: rtl/can_id_hop_encoder_if.sv
// Signal bundle between the ID hopping encoder and its neighbours: the application,
// the priority table and the CAN transmit controller.
interface can_id_hop_encoder_if;
  logic        app_valid;
  logic        app_ready;
  logic        lookup_strobe;
  logic [7:0]  priority_in;
  logic        seed_load;
  logic [3:0]  seed;
  logic        tx_valid;
  logic [10:0] tx_id;
  logic        tx_ready;
  logic        tx_done;
  logic        tx_err;
  logic [3:0]  hop_code;
  logic        drop_err;
  logic        busy;

  // The encoder side.
  modport master (
    input  app_valid, priority_in, seed_load, seed, tx_ready, tx_done, tx_err,
    output app_ready, lookup_strobe, tx_valid, tx_id, hop_code, drop_err, busy
  );

  // The environment side: application, priority table and transmit controller.
  modport slave (
    output app_valid, priority_in, seed_load, seed, tx_ready, tx_done, tx_err,
    input  app_ready, lookup_strobe, tx_valid, tx_id, hop_code, drop_err, busy
  );
endinterface

// File: rtl/can_id_hop_encoder.sv
// Transmit-side CAN ID hopping: the priority sits in the ID's upper bits and the LFSR hop code
// in the low nibble, so arbitration order is kept while the visible ID changes per epoch.
module can_id_hop_encoder #(
  parameter int unsigned HOP_FRAMES = 8,
  parameter int unsigned MAX_RETRY  = 3
) (
  input logic                   clk,
  input logic                   rst_n,
  can_id_hop_encoder_if.master  bus
);

  localparam logic [7:0] HopFramesW = HOP_FRAMES[7:0];
  localparam logic [3:0] MaxRetryW  = MAX_RETRY[3:0];

  typedef enum logic [2:0] {StIdle, StStrobe, StCapture, StOffer, StWait} state_e;

  state_e      state_q, state_d;
  logic [3:0]  retry_q, retry_d;
  logic [10:0] tx_id_q;
  logic        load_id;
  logic        tx_valid_q;
  logic        drop_q, drop_d;
  logic [3:0]  lfsr_q, lfsr_d;
  logic [7:0]  epoch_q, epoch_d;
  logic [7:0]  epoch_inc;
  logic        pri_bad;

  // x/z on the table output is treated like an invalid index.
  assign pri_bad = bus.priority_in[7] | $isunknown(bus.priority_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    drop_d  = 1'b0;
    load_id = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.app_valid) begin
          retry_d = '0;
          state_d = StStrobe;
        end
      end
      StStrobe:  state_d = StCapture;
      StCapture: begin
        if (pri_bad) begin
          drop_d  = 1'b1;
          state_d = StIdle;
        end else begin
          load_id = 1'b1;
          state_d = StOffer;
        end
      end
      StOffer: begin
        if (bus.tx_ready) state_d = StWait;
      end
      StWait: begin
        if (bus.tx_done) begin
          state_d = StIdle;
        end else if (bus.tx_err) begin
          retry_d = retry_q + 4'd1;
          if (retry_d == MaxRetryW) begin
            drop_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StOffer;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.app_ready     = (state_q == StIdle);
    bus.lookup_strobe = (state_q == StStrobe);
    bus.busy          = (state_q != StIdle);
    bus.tx_valid      = tx_valid_q;
    bus.tx_id         = tx_id_q;
    bus.drop_err      = drop_q;
    bus.hop_code      = lfsr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_q    <= '0;
      tx_id_q    <= '0;
      tx_valid_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      retry_q    <= retry_d;
      tx_valid_q <= (state_d == StOffer);
      drop_q     <= drop_d;
      if (load_id) tx_id_q <= {bus.priority_in[6:0], lfsr_q};
    end
  end

  // Epoch counting runs in every state; a seed load overrides a coincident tx_done.
  assign epoch_inc = epoch_q + 8'd1;

  always_comb begin
    lfsr_d  = lfsr_q;
    epoch_d = epoch_q;
    if (bus.seed_load) begin
      lfsr_d  = (bus.seed == 4'h0) ? 4'h1 : bus.seed;
      epoch_d = '0;
    end else if (bus.tx_done) begin
      if (epoch_inc == HopFramesW) begin
        lfsr_d  = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
        epoch_d = '0;
      end else begin
        epoch_d = epoch_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q  <= 4'h1;
      epoch_q <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      epoch_q <= epoch_d;
    end
  end

endmodule

// File: tb/tb_can_id_hop_encoder.sv
// Randomised bench for can_id_hop_encoder against a transaction-level reference model.
module tb_can_id_hop_encoder;

  localparam int unsigned HopFrames = 8;
  localparam int unsigned MaxRetry  = 3;

  logic clk;
  logic rst_n;
  can_id_hop_encoder_if bus ();

  can_id_hop_encoder #(
    .HOP_FRAMES(HopFrames),
    .MAX_RETRY (MaxRetry)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: hop code as a walk along the LFSR's 15-entry cycle, plus a frame count.
  logic [3:0] hop_seq [15];
  logic [3:0] m_hop;
  int         m_epoch;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] next_hop(input logic [3:0] cur);
    for (int i = 0; i < 15; i++) begin
      if (hop_seq[i] == cur) return hop_seq[(i + 1) % 15];
    end
    return 4'h0;
  endfunction

  task automatic model_reset();
    m_hop   = 4'h1;
    m_epoch = 0;
  endtask

  task automatic model_event(input bit sl, input logic [3:0] sd, input bit done);
    if (sl) begin
      m_hop   = (sd == 4'h0) ? 4'h1 : sd;
      m_epoch = 0;
    end else if (done) begin
      m_epoch++;
      if (m_epoch == int'(HopFrames)) begin
        m_hop   = next_hop(m_hop);
        m_epoch = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.app_valid   = 1'b0;
    bus.priority_in = 8'h00;
    bus.seed_load   = 1'b0;
    bus.seed        = 4'h0;
    bus.tx_ready    = 1'b0;
    bus.tx_done     = 1'b0;
    bus.tx_err      = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_app_ready", bus.app_ready, 1);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_tx_id", bus.tx_id, 0);
    check("rst_strobe", bus.lookup_strobe, 0);
    check("rst_drop_err", bus.drop_err, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_hop_code", bus.hop_code, 4'h1);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    model_reset();
    check_reset_values();
    rst_n = 1'b1;
    tick();
  endtask

  // Idle gap with stray controller pulses and seed loads; stray tx_done still counts.
  task automatic idle_gap(input int n);
    bit sl, dn;
    logic [3:0] sd;
    for (int i = 0; i < n; i++) begin
      sl = ($urandom_range(0, 9) == 0);
      dn = ($urandom_range(0, 5) == 0);
      sd = 4'($urandom_range(0, 15));
      bus.seed_load = sl;
      bus.seed      = sd;
      bus.tx_done   = dn;
      bus.tx_err    = ($urandom_range(0, 5) == 0);
      tick();
      clear_inputs();
      model_event(sl, sd, dn);
      check("idle_app_ready", bus.app_ready, 1);
      check("idle_tx_valid", bus.tx_valid, 0);
      check("idle_hop_code", bus.hop_code, m_hop);
    end
  endtask

  // One request: nerr failed attempts then success (nerr == MaxRetry means every attempt fails).
  // sl/sd: seed load coincident with the final controller response.
  task automatic do_req(input logic [7:0] pri, input int nerr, input bit sl,
                        input logic [3:0] sd, input bit both);
    logic [10:0] exp_id;
    int att;
    bit fin, done;
    check("req_app_ready", bus.app_ready, 1);
    bus.app_valid   = 1'b1;
    bus.priority_in = pri;
    tick();
    bus.app_valid = 1'b0;
    check("strobe_n1", bus.lookup_strobe, 1);
    check("busy_n1", bus.busy, 1);
    check("app_ready_n1", bus.app_ready, 0);
    tick();
    check("strobe_n2", bus.lookup_strobe, 0);
    check("tx_valid_n2", bus.tx_valid, 0);
    tick();
    if ($isunknown(pri) || pri[7]) begin
      check("bad_pri_drop", bus.drop_err, 1);
      check("bad_pri_no_valid", bus.tx_valid, 0);
      check("bad_pri_idle", bus.app_ready, 1);
      tick();
      check("bad_pri_drop_pulse", bus.drop_err, 0);
      check("bad_pri_no_valid2", bus.tx_valid, 0);
      return;
    end
    exp_id = {pri[6:0], m_hop};
    check("tx_valid_n3", bus.tx_valid, 1);
    check("tx_id_n3", bus.tx_id, exp_id);
    att = 0;
    while (1) begin
      repeat ($urandom_range(0, 2)) begin
        bus.tx_err = ($urandom_range(0, 3) == 0);
        tick();
        bus.tx_err = 1'b0;
        check("offer_hold_valid", bus.tx_valid, 1);
        check("offer_hold_id", bus.tx_id, exp_id);
      end
      bus.tx_ready = 1'b1;
      tick();
      bus.tx_ready = 1'b0;
      check("wait_valid_low", bus.tx_valid, 0);
      repeat ($urandom_range(0, 2)) tick();
      done = (att >= nerr);
      fin  = done || (att + 1 == int'(MaxRetry));
      bus.tx_done   = done;
      bus.tx_err    = !done || both;
      bus.seed_load = sl && fin;
      bus.seed      = sd;
      tick();
      clear_inputs();
      model_event(sl && fin, sd, done);
      if (done) begin
        check("done_app_ready", bus.app_ready, 1);
        check("done_busy", bus.busy, 0);
        check("done_hop_code", bus.hop_code, m_hop);
        check("done_tx_id_kept", bus.tx_id, exp_id);
        check("done_no_drop", bus.drop_err, 0);
        return;
      end
      att++;
      if (att == int'(MaxRetry)) begin
        check("retry_drop", bus.drop_err, 1);
        check("retry_idle", bus.app_ready, 1);
        check("retry_no_valid", bus.tx_valid, 0);
        check("retry_hop_code", bus.hop_code, m_hop);
        tick();
        check("retry_drop_pulse", bus.drop_err, 0);
        return;
      end
      check("retry_valid", bus.tx_valid, 1);
      check("retry_same_id", bus.tx_id, exp_id);
    end
  endtask

  logic [7:0] pri_x;
  int         n_offers;

  always @(posedge clk) if (rst_n && bus.tx_valid && bus.tx_ready) n_offers++;

  initial begin
    hop_seq = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    n_offers = 0;
    do_reset();

    do_req(8'h05, 0, 1'b0, 4'h0, 1'b0);
    check("first_id_const", bus.tx_id, 11'h051);

    // A full epoch of frames from reset advances the hop code once.
    do_reset();
    for (int i = 0; i < int'(HopFrames); i++) do_req(8'($urandom_range(0, 127)), 0, 1'b0, 4'h0, 1'b0);
    check("hop_after_epoch", bus.hop_code, 4'h2);
    do_req(8'h03, 0, 1'b0, 4'h0, 1'b0);
    check("ninth_id_const", bus.tx_id, 11'h032);

    n_offers = 0;
    do_req(8'h2A, int'(MaxRetry), 1'b0, 4'h0, 1'b0);
    check("retry_offer_count", 32'(n_offers), MaxRetry);

    do_req(8'h80, 0, 1'b0, 4'h0, 1'b0);
    pri_x = 8'hxx;
    do_req(pri_x, 0, 1'b0, 4'h0, 1'b0);

    do_req(8'h11, 0, 1'b0, 4'h0, 1'b0);
    do_req(8'h44, 0, 1'b1, 4'h0, 1'b0);
    check("seed0_hop", bus.hop_code, 4'h1);

    // Reset pulled mid-offer drops tx_valid without waiting for a clock edge.
    bus.app_valid   = 1'b1;
    bus.priority_in = 8'h12;
    tick();
    bus.app_valid = 1'b0;
    repeat (2) tick();
    check("pre_rst_offer", bus.tx_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_values();
    clear_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    do_req(8'h05, 0, 1'b0, 4'h0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      do_req(($urandom_range(0, 7) == 0) ? 8'($urandom_range(128, 255))
                                         : 8'($urandom_range(0, 127)),
             $urandom_range(0, MaxRetry), ($urandom_range(0, 5) == 0),
             4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
      idle_gap($urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/can_id_hop_encoder.md
# can_id_hop_encoder

Transmit-side ID hopping stage sitting directly downstream of the CAN ID priority table. It accepts a send request from the application, strobes the table to convert the application ID into a priority index, and builds the on-bus 11-bit identifier. The upper bits of that identifier carry the priority and the low nibble carries a hopping code from an LFSR, so bus arbitration order is preserved while the visible ID changes every hop epoch. It then hands the ID to the CAN transmit controller, retrying on bus error.

## Interface
- HOP_FRAMES, 8: successful frames per hop epoch (1..255).
- MAX_RETRY, 3: transmit attempts per request before the request is dropped (1..15).

- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- app_valid  in  1  application send request; the application ID is presented to the priority table by the host.
- app_ready  out  1  high only in IDLE; a request is accepted when app_valid && app_ready.
- lookup_strobe  out  1  drives the priority table's send_bit; high for exactly one cycle per request.
- priority_in  in  8  priority index from the table (its priority_sent_id output).
- seed_load  in  1  single-cycle pulse; loads the LFSR from seed.
- seed  in  4  LFSR seed; a value of 0 is replaced by 4'h1.
- tx_valid  out  1  an ID is offered to the transmit controller.
- tx_id  out  11  on-bus identifier, stable while tx_valid is high.
- tx_ready  in  1  the controller accepts the offer when tx_valid && tx_ready.
- tx_done  in  1  pulse: the frame was transmitted and acknowledged.
- tx_err  in  1  pulse: the frame failed (arbitration loss or error frame).
- hop_code  out  4  current LFSR value.
- drop_err  out  1  one-cycle pulse when a request is abandoned.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, STROBE, CAPTURE, OFFER, WAIT.
  - IDLE: app_ready=1. On acceptance, clear retry_cnt and go to STROBE.
  - STROBE: lookup_strobe=1. Always go to CAPTURE; the table registers its result on this edge.
  - CAPTURE: sample priority_in.
    - If priority_in[7]=1 or priority_in has any x/z bit: pulse drop_err and return to IDLE.
    - Otherwise latch tx_id = {priority_in[6:0], hop_code} and go to OFFER.
  - OFFER: tx_valid=1. On tx_ready, go to WAIT.
  - WAIT: wait for a result from the controller.
    - tx_done: increment the epoch counter and go to IDLE.
    - tx_err: increment retry_cnt. If the new value equals MAX_RETRY, pulse drop_err and go to IDLE; otherwise go back to OFFER with the same tx_id.
    - tx_done and tx_err in the same cycle: tx_done wins.
- LFSR: 4-bit, next = {l[2:0], l[3]^l[2]}, period 15, never reaches 0.
- Epoch counter: 8 bits. A tx_done that brings the count to HOP_FRAMES advances the LFSR one step and clears the count.
- seed_load: loads the LFSR (0 becomes 1) and clears the epoch counter.
  - If seed_load and tx_done occur in the same cycle, seed_load wins and that tx_done is not counted.
  - seed_load is honoured in any FSM state.
- An ID already latched in tx_id is never altered by a hop or a seed load; retries reuse it.
- tx_done and tx_err outside WAIT are ignored, except that tx_done still updates the epoch counter.
- app_valid outside IDLE is not accepted; the upstream side holds its request.

## Timing
- Reset values:
  - FSM in IDLE; app_ready=1.
  - tx_valid=0, tx_id=0, lookup_strobe=0, drop_err=0, busy=0.
  - hop_code=4'h1; epoch counter and retry_cnt are 0.
- Acceptance in cycle N gives:
  - lookup_strobe high in N+1;
  - priority_in sampled at the end of N+2;
  - tx_valid high from N+3.
- tx_valid is registered and stays high, with tx_id stable, until the cycle in which tx_ready is sampled high.
- After tx_done in cycle M:
  - app_ready is high in M+1;
  - hop_code reflects any LFSR advance in M+1.
- After the final tx_err, drop_err is high in the following cycle and the FSM is in IDLE.
- Reset asserted mid-operation returns all state to reset values immediately. No partial offer survives: tx_valid drops asynchronously.

## Test plan
- Reset, then request with priority_in=8'h05, hop_code=1: strobe in N+1; tx_valid in N+3 with tx_id=11'h051; tx_ready then tx_done leaves the FSM in IDLE.
- HOP_FRAMES=8, 8 consecutive successful frames from reset: hop_code goes 1→2 after the 8th tx_done; the 9th frame with priority 3 gives tx_id=11'h032.
- MAX_RETRY=3 with tx_err on every attempt: exactly 3 offers with the identical tx_id, then a drop_err pulse and return to IDLE; hop_code is unchanged.
- priority_in=8'h80, then priority_in=8'hxx: each produces a drop_err pulse in the cycle after CAPTURE and no tx_valid.
- seed_load with seed=0 while in WAIT, coincident with tx_done: hop_code becomes 1 and the epoch counter is 0; the in-flight tx_id is unchanged.
- rst_n pulled low while in OFFER: tx_valid drops immediately; after release the block accepts a new request normally.
